// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared constants, state type and sizing helper for the nibble-serial adder
//
// Purpose: common definitions imported by the controller and its adder slice.
//   SLICE_W   : bits processed per RUN cycle
//   state_t   : controller states (IDLE, RUN, DONE)
//   idx_width : width of the nibble index register for a given operand width
package nibble_serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Enough bits to count nibbles 0 .. width/SLICE_W-1; never narrower than one bit.
  function automatic int idx_width(input int width);
    int nibbles;
    nibbles = width / SLICE_W;
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/add_slice_4.sv
// rtl/add_slice_4.sv - combinational 4-bit ripple adder slice built from full-adder cells
//
// Purpose: adds one nibble of each operand plus a carry-in.
// Ports:
//   a, b : operand nibbles
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (XOR with co gives signed overflow on the top slice)
module add_slice_4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  // c[i] is the carry into bit i; c[SLICE_W] leaves the slice.
  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[SLICE_W];
  assign c3 = c[SLICE_W-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
//
// Purpose: one-bit sum and carry from two operand bits and a carry-in.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial add/subtract controller using one 4-bit slice
//
// Purpose: computes a+b+cin or a-b over WIDTH/4 RUN cycles, one nibble per cycle,
//          LSB nibble first, then pulses done for one cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : operation request, sampled only while ready
//   sub   : 0 = add with carry-in, 1 = subtract (a + ~b + 1)
//   a, b  : operands
//   cin   : carry-in for add
//   ready : high in IDLE
//   busy  : high in RUN
//   done  : one-cycle pulse in DONE
//   sum   : result, held until the next accepted start
//   cout  : final carry (subtract: 1 = no borrow)
//   ovf   : two's-complement signed overflow
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = idx_width(WIDTH);
  localparam int SHIFT_W = $clog2(SLICE_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  // Control strobes decoded by the FSM.
  logic accept;
  logic step;
  logic last;

  // Slice connections.
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_c3;

  // Bit offset of the current nibble; widths line up so the part-select index is exact.
  logic [IDX_W+SHIFT_W-1:0] bit_off;

  assign bit_off = {idx_r, {SHIFT_W{1'b0}}};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx_r == LAST_IDX) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign slice_a = a_r[bit_off +: SLICE_W];
  // Subtract feeds ~b; the +1 comes from the carry register preset on entry.
  assign slice_b = b_r[bit_off +: SLICE_W] ^ {SLICE_W{sub_r}};

  add_slice_4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_r),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      sub_r   <= sub;
      carry_r <= sub ? 1'b1 : cin;
      idx_r   <= '0;
    end else if (step) begin
      sum_r[bit_off +: SLICE_W] <= slice_s;
      carry_r                   <= slice_co;
      idx_r                     <= idx_r + IDX_W'(1);
      if (last) begin
        cout_r <= slice_co;
        // Carry into the MSB differs from carry out of it exactly on signed overflow.
        ovf_r  <= slice_c3 ^ slice_co;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Arithmetic reference: {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {ov, co, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing model: k counts cycles since acceptance (0 = idle, 1..NIB = running, NIB+1 = done).
  int           k = 0;
  logic [W+1:0] pend = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      k      <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (k == 0) begin
      if (start) begin
        k    <= 1;
        pend <= ref_calc(a, b, sub, cin);
      end
    end else if (k == NIB) begin
      k      <= NIB + 1;
      m_sum  <= pend[W-1:0];
      m_cout <= pend[W];
      m_ovf  <= pend[W+1];
    end else if (k == NIB + 1) begin
      k <= 0;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, ready}, {31'd0, (k == 0)});
      check("busy",  {31'd0, busy},  {31'd0, (k >= 1 && k <= NIB)});
      check("done",  {31'd0, done},  {31'd0, (k == NIB + 1)});
      if (!(k >= 1 && k <= NIB)) begin
        check("sum",  {16'd0, sum},   {16'd0, m_sum});
        check("cout", {31'd0, cout},  {31'd0, m_cout});
        check("ovf",  {31'd0, ovf},   {31'd0, m_ovf});
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Called at a negedge with the DUT idle: issues one operation, scrambles inputs
  // while it runs and checks latency and result against literals. Returns at the done negedge.
  task automatic op_lit(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input logic xc, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int          n;
    bit          got;
    logic [W+1:0] r;
    r = ref_calc(xa, xb, xs, xc);
    check({name, "_model"}, {14'd0, r}, {14'd0, eo, ec, es});
    a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (done) got = 1'b1;
    end
    check({name, "_latency"}, n, 5);
    check({name, "_sum"},  {16'd0, sum}, {16'd0, es});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   dones;
    int   stamps[$];

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    start  = 1'b1;  // reset must win over start
    a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_sum",   {16'd0, sum},   32'd0);

    // First start accepted on the first edge with rst_n high.
    rst_n = 1'b1;
    op_lit("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    op_lit("add_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    op_lit("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    op_lit("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
    op_lit("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Start pulse and operand changes while running are ignored.
    @(negedge clk);
    a = 16'h1000; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    dones = 0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = (n == 2);
      a = (n == 2) ? 16'h0001 : W'($urandom);
      b = W'($urandom);
      if (done) begin
        dones++;
        check("ignore_done_at", n, 5);
        check("ignore_sum", {16'd0, sum}, 32'h1001);
      end
      if (n == 7) check("ignore_no_restart", {31'd0, busy}, 32'd0);
    end
    check("ignore_done_count", dones, 1);

    // Reset in the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (n = 1; n <= 3; n++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_no_early_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_done",  {31'd0, done},  32'd0);
    check("abort_sum",   {16'd0, sum},   32'd0);
    rst_n = 1'b1;
    op_lit("after_abort", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Start held high: one accepted operation every NIB+2 cycles.
    @(negedge clk);
    start = 1'b1;
    for (n = 0; n < 40; n++) begin
      a = pick(); b = pick(); sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) stamps.push_back(cyc);
    end
    start = 1'b0;
    check("b2b_count_ok", {31'd0, (stamps.size() >= 6)}, 32'd1);
    for (int i = 1; i < stamps.size(); i++) begin
      check("b2b_interval", stamps[i] - stamps[i-1], NIB + 2);
    end
    repeat (8) @(negedge clk);

    // Random traffic with occasional resets, checked cycle by cycle by the model.
    dones = 0;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 2) == 0);
      a = pick(); b = pick(); sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) dones++;
    end
    check("random_ops_completed", {31'd0, (dones > 100)}, 32'd1);

    rst_n = 1'b1; start = 1'b0;
    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only while ready=1.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 = add (a+b+cin), 1 = subtract (a-b, computed as a+~b+1, with cin ignored).
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, used for add only.
REQ-008 The block SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN only.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high in DONE only.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: final carry out; in subtract, cout=1 means no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b, sub and cin on that edge, clear the nibble index to 0, and go to RUN.
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-017 In RUN, each cycle SHALL process nibble idx (bits 4*idx+3 : 4*idx, LSB nibble first) through one 4-bit adder slice.
REQ-018 Slice operand B for each RUN cycle SHALL be the latched b nibble, inverted when sub=1.
REQ-019 Slice carry-in SHALL come from the carry register, which is loaded on the RUN entry edge with cin for add and with 1 for subtract.
REQ-020 At the end of each RUN cycle, the slice sum SHALL be written into sum[4*idx+3 : 4*idx], the slice carry-out SHALL go to the carry register, and idx SHALL increment.
REQ-021 After the cycle with idx = WIDTH/4-1, the block SHALL load cout from the final carry, load ovf, and go to DONE.
REQ-022 ovf SHALL be the XOR of the carry into the MSB and the carry out of the MSB, captured from the last slice.
REQ-023 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-024 Latency: if start is accepted on edge T, done SHALL be high in the cycle after edge T+WIDTH/4 (5 cycles after acceptance for WIDTH=16), and ready SHALL be high again one cycle later.
REQ-025 Throughput SHALL be one operation per WIDTH/4+2 cycles.
REQ-026 start while busy=1 or done=1 SHALL be ignored: it does not queue and does not alter the latched operands.
REQ-027 Changes on a, b, sub or cin after acceptance SHALL have no effect on the operation in progress.
REQ-028 sum, cout and ovf SHALL hold their last result through IDLE until the next accepted start.
REQ-029 sum bits above the current idx are undefined to observers during RUN; they are valid only while done=1 and afterwards in IDLE.
REQ-030 All operand arithmetic SHALL be modulo 2^WIDTH, with the carry carried separately in the carry register.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL go to IDLE and clear sum, cout, ovf, idx, the carry register and the operand registers to 0.
REQ-032 Reset values SHALL be ready=1, busy=0, done=0.
REQ-033 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-034 The first start SHALL be accepted on the first edge at which rst_n=1.
REQ-035 Reset SHALL take priority over start on the same edge.

Structure
REQ-036 A shared package SHALL hold SLICE_W=4, the state enum (IDLE/RUN/DONE), and a function giving the index width from WIDTH.
REQ-037 The 4-bit adder slice SHALL be one sub-module, add_slice_4, combinational with ports a[3:0], b[3:0], ci, s[3:0], co, and c3 (the carry into bit 3, used for ovf), built from full-adder cells.
REQ-038 The controller SHALL instantiate add_slice_4 exactly once; no wide "+" operator is permitted in the controller.

Verification
REQ-039 Add 0x1234 + 0x1111 with cin=0 -> sum=0x2345, cout=0, ovf=0; done high exactly 5 cycles after acceptance.
REQ-040 Add 0xFFFF + 0x0000 with cin=1 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all nibbles).
REQ-041 Add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0. Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-042 Pulse start with a=0x0001 two cycles after the accepted start of 0x1000+0x0001, and change a and b mid-RUN -> result stays 0x1001, only one done pulse, and no second operation starts.
REQ-043 Assert rst_n=0 at the third RUN cycle -> next cycle ready=1, busy=0, sum=0, no done pulse; a new start after release completes correctly.
REQ-044 Back-to-back starts held continuously high -> an operation is accepted every 6 cycles, each result is correct, and ready is low from acceptance until after DONE.
